// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage,
// valid/ready handshake with a global stall (no bubble collapsing).
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTG = WIDTH / BLK;

    logic adv;

    // Per-stage registers: operands carried forward, resolved sum bits, block carry, valid
    logic [WIDTH-1:0] a_p   [NSTG];
    logic [WIDTH-1:0] b_p   [NSTG];
    logic [WIDTH-1:0] res_p [NSTG];
    logic             c_p   [NSTG];
    logic             vld_p [NSTG];
    logic             ovf_p;

    logic [WIDTH-1:0] a_i [NSTG];
    logic [WIDTH-1:0] b_i [NSTG];
    logic [WIDTH-1:0] r_i [NSTG];
    logic [WIDTH-1:0] r_n [NSTG];
    logic             c_i [NSTG];
    logic             c_n [NSTG];
    logic [BLK:0]     s0  [NSTG];
    logic [BLK:0]     s1  [NSTG];
    logic             ovf_n;

    function automatic logic [BLK:0] blk_add(input logic [BLK-1:0] x,
                                             input logic [BLK-1:0] y,
                                             input logic           c);
        return {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, c};
    endfunction

    assign adv      = !vld_p[NSTG-1] || out_ready;
    assign in_ready = adv;

    always_comb begin
        // Subtraction is A + ~B + 1; cin only matters in add mode
        a_i[0] = a;
        b_i[0] = sub ? ~b : b;
        c_i[0] = sub ? 1'b1 : cin;
        r_i[0] = '0;
        for (int k = 1; k < NSTG; k++) begin
            a_i[k] = a_p[k-1];
            b_i[k] = b_p[k-1];
            c_i[k] = c_p[k-1];
            r_i[k] = res_p[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            s0[k] = blk_add(a_i[k][k*BLK +: BLK], b_i[k][k*BLK +: BLK], 1'b0);
            s1[k] = blk_add(a_i[k][k*BLK +: BLK], b_i[k][k*BLK +: BLK], 1'b1);
            r_n[k] = r_i[k];
            r_n[k][k*BLK +: BLK] = c_i[k] ? s1[k][BLK-1:0] : s0[k][BLK-1:0];
            c_n[k] = c_i[k] ? s1[k][BLK] : s0[k][BLK];
        end
        // Carry into the MSB is recovered from the MSB sum bit and its operand bits
        ovf_n = a_i[NSTG-1][WIDTH-1] ^ b_i[NSTG-1][WIDTH-1] ^ r_n[NSTG-1][WIDTH-1] ^ c_n[NSTG-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                res_p[k] <= '0;
                c_p[k]   <= 1'b0;
            end
            ovf_p <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < NSTG; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            for (int k = 0; k < NSTG; k++) begin
                a_p[k]   <= a_i[k];
                b_p[k]   <= b_i[k];
                res_p[k] <= r_n[k];
                c_p[k]   <= c_n[k];
            end
            ovf_p <= ovf_n;
        end
    end

    assign out_valid = vld_p[NSTG-1];
    assign sum       = res_p[NSTG-1];
    assign cout      = c_p[NSTG-1];
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Randomized and directed bench for pipelined_csel_adder (WIDTH=16, BLK=4),
// checked against an integer-arithmetic reference model.
module tb_pipelined_csel_adder;
    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NSTG  = WIDTH / BLK;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] a = '0, b = '0, sum;
    logic        cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b0, cout, ovf;

    pipelined_csel_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0, n_fail = 0, cyc = 0, obs_cyc = 0;
    logic        obs_valid, obs_ready, obs_cout, obs_ovf;
    logic [15:0] obs_sum;

    // Reference: exact integer arithmetic, then range checks for carry and overflow
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic s, input int c);
        exp_t   e;
        int     sx, sy, r;
        longint ux, uy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        if (s) begin
            r   = sx - sy;
            e.s = x - y;
            e.c = (ux >= uy);
        end else begin
            r   = sx + sy + int'(ci);
            e.s = x + y + {15'b0, ci};
            e.c = (ux + uy + longint'(ci)) > 64'd65535;
        end
        e.v   = (r > 32767) || (r < -32768);
        e.cyc = c;
        return e;
    endfunction

    // One clock: drive inputs just after posedge, sample at negedge, record accepted input
    task automatic cycle(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic s, input logic ordy);
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = ci;
        sub       = s;
        out_ready = ordy;
        @(negedge clk);
        obs_valid = out_valid;
        obs_ready = in_ready;
        obs_sum   = sum;
        obs_cout  = cout;
        obs_ovf   = ovf;
        obs_cyc   = cyc;
        if (v && in_ready) exp_q.push_back(model(x, y, ci, s, cyc));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_tests++;
        if ({sum, cout, ovf} !== 18'h0) begin
            n_fail++; $display("FAIL reset_outputs got=%h/%b/%b want=0000/0/0", sum, cout, ovf);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] tb [5] = '{16'h1111, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
        logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] tx [5] = '{{16'h2345, 2'b00}, {16'h0000, 2'b10}, {16'h8000, 2'b01},
                                {16'hFFFE, 2'b00}, {16'h7FFF, 2'b11}};
        exp_t e;
        int   j = 0;
        for (int i = 0; i < 5 + 12; i++) begin
            if (i < 5) cycle(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1);
            else       cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (obs_valid) begin
                n_tests++;
                if (exp_q.size() == 0 || j >= 5) begin
                    n_fail++; $display("FAIL directed_stray sum=%h want no result", obs_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_sum, obs_cout, obs_ovf} !== tx[j]) begin
                        n_fail++;
                        $display("FAIL directed_%0d got=%h/%b/%b want=%h/%b/%b", j, obs_sum,
                                 obs_cout, obs_ovf, tx[j][17:2], tx[j][1], tx[j][0]);
                    end
                    n_tests++;
                    if (obs_cyc - e.cyc != NSTG) begin
                        n_fail++;
                        $display("FAIL directed_latency_%0d got=%0d want=%0d", j, obs_cyc - e.cyc, NSTG);
                    end
                    j++;
                end
            end
        end
        n_tests++;
        if (j != 5) begin
            n_fail++; $display("FAIL directed_count got=%0d want=5", j);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cnt = 0, first = -1, last = -1;
        for (int i = 0; i < 8 + 10; i++) begin
            if (i < 8) cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            else       cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (obs_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_stray sum=%h want no result", obs_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_sum, obs_cout, obs_ovf} !== {e.s, e.c, e.v}) begin
                        n_fail++;
                        $display("FAIL b2b_result_%0d got=%h/%b/%b want=%h/%b/%b", cnt,
                                 obs_sum, obs_cout, obs_ovf, e.s, e.c, e.v);
                    end
                    if (first < 0) first = obs_cyc;
                    last = obs_cyc;
                    cnt++;
                end
            end
        end
        n_tests++;
        if (cnt != 8 || last - first != 7) begin
            n_fail++; $display("FAIL b2b_consecutive got=%0d results over %0d cycles want=8 over 8", cnt, last - first + 1);
        end
    endtask

    task automatic test_stall();
        exp_t        e;
        logic [17:0] snap;
        int          cnt = 0;
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        snap = {obs_sum, obs_cout, obs_ovf};
        n_tests++;
        if (obs_valid !== 1'b1 || obs_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_full got valid=%b ready=%b want valid=1 ready=0", obs_valid, obs_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || {obs_sum, obs_cout, obs_ovf} !== snap) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got ready=%b valid=%b out=%h want ready=0 valid=1 out=%h",
                         i, obs_ready, obs_valid, {obs_sum, obs_cout, obs_ovf}, snap);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (obs_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stall_stray sum=%h want no result", obs_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_sum, obs_cout, obs_ovf} !== {e.s, e.c, e.v}) begin
                        n_fail++;
                        $display("FAIL stall_drain_%0d got=%h/%b/%b want=%h/%b/%b", cnt,
                                 obs_sum, obs_cout, obs_ovf, e.s, e.c, e.v);
                    end
                    cnt++;
                end
            end
        end
        n_tests++;
        if (cnt != 4 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stall_drain_count got=%0d left=%0d want=4 left=0", cnt, exp_q.size());
        end
    endtask

    task automatic test_random_flow();
        exp_t e;
        for (int i = 0; i < 100; i++) begin
            if (i < 80)
                cycle(1'($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 6));
            else
                cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (obs_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL random_stray sum=%h want no result", obs_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_sum, obs_cout, obs_ovf} !== {e.s, e.c, e.v}) begin
                        n_fail++;
                        $display("FAIL random_result cyc=%0d got=%h/%b/%b want=%h/%b/%b", obs_cyc,
                                 obs_sum, obs_cout, obs_ovf, e.s, e.c, e.v);
                    end
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL random_drain left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_flight();
        exp_t e;
        int   cnt = 0;
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || {sum, cout, ovf} !== 18'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_reset got valid=%b out=%h ready=%b want valid=0 out=0 ready=1",
                     out_valid, {sum, cout, ovf}, in_ready);
        end
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (obs_ready !== 1'b1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL flight_first_transfer got ready=%b queued=%0d want ready=1 queued=1", obs_ready, exp_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (obs_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL flight_stale sum=%h want no result", obs_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_sum, obs_cout, obs_ovf} !== {e.s, e.c, e.v}) begin
                        n_fail++;
                        $display("FAIL flight_result got=%h/%b/%b want=%h/%b/%b",
                                 obs_sum, obs_cout, obs_ovf, e.s, e.c, e.v);
                    end
                    cnt++;
                end
            end
        end
        n_tests++;
        if (cnt != 1) begin
            n_fail++; $display("FAIL flight_count got=%0d want=1", cnt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random_flow();
        test_reset_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
